// File: rtl/meduram_pkg.sv
// Shared definitions for the multi-agent BRAM wrapper: bank id sizing used by
// the bank accounter and the read switch.
package meduram_pkg;

   localparam int DEFAULT_NB_WRAGENT = 2;

   function automatic int sel_width(input int n);
      return (n == 1) ? 1 : $clog2(n);
   endfunction

   typedef logic [sel_width(DEFAULT_NB_WRAGENT)-1:0] bank_id_t;

endpackage

// File: rtl/bank_accounter_wr_prio_encoder.sv
// Matches all write agents against one target address and reports whether any
// hit, together with the highest-index hitting agent.
module wr_prio_encoder #(
   parameter int NB_WRAGENT   = 2,
   parameter int ADDR_WIDTH   = 8,
   parameter int SELECT_WIDTH = 1
) (
   input  logic [NB_WRAGENT-1:0]            wren,
   input  logic [NB_WRAGENT*ADDR_WIDTH-1:0] wraddr,
   input  logic [ADDR_WIDTH-1:0]            target,
   output logic                             hit,
   output logic [SELECT_WIDTH-1:0]          id
);

   // later agents overwrite earlier ones, so the highest index wins
   always_comb begin
      hit = 1'b0;
      id  = {SELECT_WIDTH{1'b0}};
      for (int i = 0; i < NB_WRAGENT; i++) begin
         if (wren[i] && (wraddr[ADDR_WIDTH*i +: ADDR_WIDTH] == target)) begin
            hit = 1'b1;
            id  = SELECT_WIDTH'(i);
         end else begin
            hit = hit;
         end
      end
   end

endmodule

// File: rtl/bank_accounter.sv
// Per-address ownership table: records which write agent (bank) last wrote each
// address and serves the bank selector to the read agents.
module bank_accounter
   import meduram_pkg::*;
#(
   parameter int ADDR_WIDTH   = 8,
   parameter int NB_WRAGENT   = 2,
   parameter int NB_RDAGENT   = 2,
   parameter int SELECT_WIDTH = sel_width(NB_WRAGENT),
   parameter int CNT_WIDTH    = 16
) (
   input  logic                               aclk,
   input  logic                               areset,
   input  logic [NB_WRAGENT-1:0]              wren,
   input  logic [NB_WRAGENT*ADDR_WIDTH-1:0]   wraddr,
   input  logic [NB_RDAGENT-1:0]              rden,
   input  logic [NB_RDAGENT*ADDR_WIDTH-1:0]   rdaddr,
   output logic [NB_RDAGENT*SELECT_WIDTH-1:0] rdselect,
   output logic                               wrcollision,
   output logic [CNT_WIDTH-1:0]               collision_cnt,
   input  logic                               clr_stats
);

   localparam int ENTRIES = 2 ** ADDR_WIDTH;

   logic [SELECT_WIDTH-1:0] entry_r [ENTRIES];
   logic                    hit_s   [ENTRIES];
   logic [SELECT_WIDTH-1:0] id_s    [ENTRIES];
   logic                    coll_s;

   for (genvar a = 0; a < ENTRIES; a++) begin : g_entry
      wr_prio_encoder #(
         .NB_WRAGENT  (NB_WRAGENT),
         .ADDR_WIDTH  (ADDR_WIDTH),
         .SELECT_WIDTH(SELECT_WIDTH)
      ) u_enc (
         .wren  (wren),
         .wraddr(wraddr),
         .target(ADDR_WIDTH'(a)),
         .hit   (hit_s[a]),
         .id    (id_s[a])
      );
   end

   // ownership table; kept in flops so reset can clear every entry at once
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         for (int a = 0; a < ENTRIES; a++) begin
            entry_r[a] <= {SELECT_WIDTH{1'b0}};
         end
      end else begin
         for (int a = 0; a < ENTRIES; a++) begin
            if (hit_s[a]) begin
               entry_r[a] <= id_s[a];
            end
         end
      end
   end

   // zero-latency lookup; a same-cycle write is not forwarded (read-before-write)
   always_comb begin
      rdselect = {(NB_RDAGENT*SELECT_WIDTH){1'b0}};
      for (int j = 0; j < NB_RDAGENT; j++) begin
         if (rden[j]) begin
            rdselect[SELECT_WIDTH*j +: SELECT_WIDTH] = entry_r[rdaddr[ADDR_WIDTH*j +: ADDR_WIDTH]];
         end else begin
            rdselect[SELECT_WIDTH*j +: SELECT_WIDTH] = {SELECT_WIDTH{1'b0}};
         end
      end
   end

   // any pair of agents writing the same address this cycle
   always_comb begin
      coll_s = 1'b0;
      for (int i = 0; i < NB_WRAGENT; i++) begin
         for (int k = i + 1; k < NB_WRAGENT; k++) begin
            if (wren[i] && wren[k] &&
                (wraddr[ADDR_WIDTH*i +: ADDR_WIDTH] == wraddr[ADDR_WIDTH*k +: ADDR_WIDTH])) begin
               coll_s = 1'b1;
            end else begin
               coll_s = coll_s;
            end
         end
      end
   end

   // collision pulse and saturating statistics; clear beats increment
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         wrcollision   <= 1'b0;
         collision_cnt <= {CNT_WIDTH{1'b0}};
      end else begin
         wrcollision <= coll_s;
         if (clr_stats) begin
            collision_cnt <= {CNT_WIDTH{1'b0}};
         end else if (coll_s && (collision_cnt != {CNT_WIDTH{1'b1}})) begin
            collision_cnt <= collision_cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
         end
      end
   end

endmodule

// File: tb/tb_bank_accounter.sv
// Self-checking bench for bank_accounter: directed scenarios plus random traffic
// against an address-ownership model.
module tb_bank_accounter;

   logic        clk;
   logic        rst;
   logic [1:0]  wren;
   logic [15:0] wraddr;
   logic [1:0]  rden;
   logic [15:0] rdaddr;
   logic        clr;
   logic [1:0]  rdselect;
   logic        wrcollision;
   logic [15:0] cnt;
   logic [1:0]  rdselect2;
   logic        wrcoll2;
   logic [1:0]  cnt2;

   int n_checks = 0;
   int n_fail   = 0;

   bit model_tbl [256];
   int model_cnt;
   int model_cnt2;
   bit model_coll;

   bank_accounter dut (
      .aclk(clk), .areset(rst), .wren(wren), .wraddr(wraddr), .rden(rden),
      .rdaddr(rdaddr), .rdselect(rdselect), .wrcollision(wrcollision),
      .collision_cnt(cnt), .clr_stats(clr)
   );

   bank_accounter #(.CNT_WIDTH(2)) dut2 (
      .aclk(clk), .areset(rst), .wren(wren), .wraddr(wraddr), .rden(rden),
      .rdaddr(rdaddr), .rdselect(rdselect2), .wrcollision(wrcoll2),
      .collision_cnt(cnt2), .clr_stats(clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [1:0] exp_sel();
      logic [1:0] e;
      for (int j = 0; j < 2; j++) begin
         e[j] = rden[j] ? model_tbl[rdaddr[8*j +: 8]] : 1'b0;
      end
      return e;
   endfunction

   function automatic bit cur_coll();
      return (wren == 2'b11) && (wraddr[7:0] == wraddr[15:8]);
   endfunction

   function automatic void model_reset();
      foreach (model_tbl[a]) model_tbl[a] = 1'b0;
      model_cnt  = 0;
      model_cnt2 = 0;
      model_coll = 1'b0;
   endfunction

   // clock edge: model sees the inputs present at the edge, then inputs may change
   task automatic step();
      bit c;
      @(posedge clk);
      c = cur_coll();
      for (int i = 0; i < 2; i++) begin
         if (wren[i]) model_tbl[wraddr[8*i +: 8]] = 1'(i);
      end
      if (clr) begin
         model_cnt  = 0;
         model_cnt2 = 0;
      end else if (c) begin
         if (model_cnt < 65535) model_cnt++;
         if (model_cnt2 < 3) model_cnt2++;
      end
      model_coll = c;
      #1;
   endtask

   task automatic idle_inputs();
      wren = 2'b00; wraddr = 16'h0000; rden = 2'b00; rdaddr = 16'h0000; clr = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1'b1;
      model_reset();
      rden = 2'b11; rdaddr = {8'h10, 8'h05};
      #3;
      n_checks++;
      if (rdselect !== 2'b00) begin n_fail++; $display("FAIL reset_rdselect got %b want 00", rdselect); end
      n_checks++;
      if (wrcollision !== 1'b0) begin n_fail++; $display("FAIL reset_wrcoll got %b want 0", wrcollision); end
      n_checks++;
      if (cnt !== 16'h0000) begin n_fail++; $display("FAIL reset_cnt got %h want 0000", cnt); end
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_write_read();
      wren = 2'b11; wraddr = {8'h05, 8'h10};
      rden = 2'b01; rdaddr = {8'h00, 8'h05};
      @(negedge clk);
      n_checks++;
      if (rdselect[0] !== 1'b0) begin n_fail++; $display("FAIL wr_old_value got %b want 0", rdselect[0]); end
      step();
      wren = 2'b00; rden = 2'b11; rdaddr = {8'h10, 8'h05};
      @(negedge clk);
      n_checks++;
      if (rdselect !== 2'b01) begin n_fail++; $display("FAIL wr_new_value got %b want 01", rdselect); end
      n_checks++;
      if (wrcollision !== 1'b0) begin n_fail++; $display("FAIL wr_no_coll got %b want 0", wrcollision); end
      step();
   endtask

   task automatic test_collision();
      wren = 2'b11; wraddr = {8'h22, 8'h22}; rden = 2'b00;
      step();
      wren = 2'b00; rden = 2'b01; rdaddr = {8'h00, 8'h22};
      @(negedge clk);
      n_checks++;
      if (rdselect[0] !== 1'b1) begin n_fail++; $display("FAIL coll_owner got %b want 1", rdselect[0]); end
      n_checks++;
      if (wrcollision !== 1'b1) begin n_fail++; $display("FAIL coll_pulse got %b want 1", wrcollision); end
      n_checks++;
      if (cnt !== 16'd1) begin n_fail++; $display("FAIL coll_cnt got %0d want 1", cnt); end
      step();
      n_checks++;
      if (wrcollision !== 1'b0) begin n_fail++; $display("FAIL coll_pulse_end got %b want 0", wrcollision); end
      n_checks++;
      if (cnt !== 16'd1) begin n_fail++; $display("FAIL coll_cnt_hold got %0d want 1", cnt); end
   endtask

   task automatic test_saturation();
      logic [1:0] seq [4];
      seq[0] = 2'd1; seq[1] = 2'd2; seq[2] = 2'd3; seq[3] = 2'd3;
      clr = 1'b1;
      step();
      clr = 1'b0;
      for (int n = 0; n < 4; n++) begin
         wren = 2'b11; wraddr = {8'h40, 8'h40};
         step();
         n_checks++;
         if (cnt2 !== seq[n]) begin n_fail++; $display("FAIL sat_cnt2[%0d] got %0d want %0d", n, cnt2, seq[n]); end
         n_checks++;
         if (cnt !== 16'(n + 1)) begin n_fail++; $display("FAIL sat_cnt[%0d] got %0d want %0d", n, cnt, n + 1); end
      end
      clr = 1'b1;
      step();
      clr = 1'b0; wren = 2'b00;
      n_checks++;
      if (cnt !== 16'd0 || cnt2 !== 2'd0) begin n_fail++; $display("FAIL clr_wins got %0d/%0d want 0/0", cnt, cnt2); end
      n_checks++;
      if (wrcollision !== 1'b1) begin n_fail++; $display("FAIL clr_pulse got %b want 1", wrcollision); end
      step();
   endtask

   task automatic test_rden_mask();
      rden = 2'b01; rdaddr = {8'h05, 8'h05};
      @(negedge clk);
      n_checks++;
      if (rdselect !== 2'b01) begin n_fail++; $display("FAIL rden_mask got %b want 01", rdselect); end
      step();
   endtask

   task automatic test_random();
      logic [1:0] e;
      for (int n = 0; n < 300; n++) begin
         wren   = 2'($urandom_range(3));
         wraddr = {8'($urandom_range(7)), 8'($urandom_range(7))};
         rden   = 2'($urandom_range(3));
         rdaddr = {8'($urandom_range(7)), 8'($urandom_range(7))};
         clr    = ($urandom_range(15) == 0);
         @(negedge clk);
         e = exp_sel();
         n_checks++;
         if (rdselect !== e || rdselect2 !== e) begin
            n_fail++; $display("FAIL rnd_rdselect[%0d] got %b/%b want %b", n, rdselect, rdselect2, e);
         end
         n_checks++;
         if (wrcollision !== model_coll) begin
            n_fail++; $display("FAIL rnd_wrcoll[%0d] got %b want %b", n, wrcollision, model_coll);
         end
         n_checks++;
         if (cnt !== 16'(model_cnt) || cnt2 !== 2'(model_cnt2)) begin
            n_fail++; $display("FAIL rnd_cnt[%0d] got %0d/%0d want %0d/%0d", n, cnt, cnt2, model_cnt, model_cnt2);
         end
         step();
      end
      idle_inputs();
   endtask

   task automatic test_reset_mid();
      wren = 2'b11; wraddr = {8'h30, 8'h30};
      step();
      wren = 2'b10; wraddr = {8'h31, 8'h00};
      rden = 2'b11; rdaddr = {8'h31, 8'h30};
      @(negedge clk);
      n_checks++;
      if (rdselect !== 2'b01) begin n_fail++; $display("FAIL pre_rst_owner got %b want 01", rdselect); end
      #2;
      rst = 1'b1;
      model_reset();
      #1;
      n_checks++;
      if (rdselect !== 2'b00) begin n_fail++; $display("FAIL mid_rst_rdselect got %b want 00", rdselect); end
      n_checks++;
      if (cnt !== 16'd0 || wrcollision !== 1'b0) begin
         n_fail++; $display("FAIL mid_rst_stats got %0d/%b want 0/0", cnt, wrcollision);
      end
      @(posedge clk); #1;
      n_checks++;
      if (rdselect !== 2'b00) begin n_fail++; $display("FAIL rst_held_rdselect got %b want 00", rdselect); end
      wren = 2'b00;
      @(negedge clk);
      rst = 1'b0;
      step();
      n_checks++;
      if (rdselect !== 2'b00) begin n_fail++; $display("FAIL post_rst_lost_write got %b want 00", rdselect); end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_collision();
      test_saturation();
      test_rden_mask();
      test_random();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
